// File: rtl/p4_mem_if.sv
// Data-memory bus between the P4 memory stage and the memory subsystem.
// The master issues a request; the slave grants it and later returns a response.
interface p4_mem_if;
  logic        mem_req;
  logic        mem_gnt;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        mem_err;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_gnt, mem_rvalid, mem_rdata, mem_err
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_gnt, mem_rvalid, mem_rdata, mem_err
  );
endinterface

// File: rtl/p4_mem.sv
// P4 memory stage: issues one load/store per instruction on the data bus,
// stalling the pipeline until the response arrives or the access times out.
module p4_mem #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  input  logic        i_mem_rd,
  input  logic        i_mem_wr,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_alu_out,
  input  logic [31:0] i_rd_data2,
  output logic        o_stall,
  output logic [31:0] o_load_data,
  output logic        o_done,
  output logic        o_misaligned,
  output logic        o_bus_err,
  p4_mem_if.master    mem
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  state_t      state, state_d;
  logic [CW-1:0] cnt;
  logic        req_q, we_q;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  wstrb_q;
  logic [2:0]  f3_q;
  logic [1:0]  alo_q;

  logic        is_mem, aligned, start, timeout, resp_ok, finish;
  logic [3:0]  wstrb_n;
  logic [31:0] wdata_n, shifted, load_ext;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // funct3[1:0]: 00 byte, 01 half, anything else behaves as a word
  always_comb begin
    is_mem  = i_valid & (i_mem_rd | i_mem_wr);
    unique case (i_funct3[1:0])
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~i_alu_out[0];
      default: aligned = (i_alu_out[1:0] == 2'b00);
    endcase
    start        = (state == IDLE) & is_mem & aligned;
    o_misaligned = (state == IDLE) & is_mem & ~aligned;
    o_stall      = start | (state == REQ) | (state == RESP);
  end

  always_comb begin
    wstrb_n = '0;
    wdata_n = '0;
    if (i_mem_wr) begin
      unique case (i_funct3[1:0])
        2'b00: begin
          wstrb_n = 4'b0001 << i_alu_out[1:0];
          wdata_n = {4{i_rd_data2[7:0]}};
        end
        2'b01: begin
          wstrb_n = 4'b0011 << {i_alu_out[1], 1'b0};
          wdata_n = {2{i_rd_data2[15:0]}};
        end
        default: begin
          wstrb_n = 4'hF;
          wdata_n = i_rd_data2;
        end
      endcase
    end
  end

  always_comb begin
    shifted  = mem.mem_rdata >> {alo_q, 3'b000};
    byte_sel = shifted[7:0];
    half_sel = alo_q[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];
    unique case (f3_q)
      3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  load_ext = {24'h0, byte_sel};
      3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
      3'b101:  load_ext = {16'h0, half_sel};
      default: load_ext = mem.mem_rdata;
    endcase
  end

  // In RESP a response beats a simultaneous timeout; in REQ the timeout wins over a grant
  always_comb begin
    timeout = (cnt == CW'(TIMEOUT_CYCLES - 1));
    resp_ok = (state == RESP) & mem.mem_rvalid;
    finish  = resp_ok | (((state == REQ) | (state == RESP)) & timeout);
    state_d = state;
    unique case (state)
      IDLE: if (start) state_d = REQ;
      REQ:  if (timeout) state_d = DONE;
            else if (mem.mem_gnt) state_d = RESP;
      RESP: if (finish) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      f3_q        <= '0;
      alo_q       <= '0;
      o_load_data <= '0;
      o_done      <= 1'b0;
      o_bus_err   <= 1'b0;
    end else begin
      state     <= state_d;
      o_done    <= (state_d == DONE);
      o_bus_err <= 1'b0;
      if (start) begin
        cnt     <= '0;
        req_q   <= 1'b1;
        we_q    <= i_mem_wr;
        addr_q  <= {i_alu_out[31:2], 2'b00};
        wdata_q <= wdata_n;
        wstrb_q <= wstrb_n;
        f3_q    <= i_funct3;
        alo_q   <= i_alu_out[1:0];
      end else if ((state == REQ) | (state == RESP)) begin
        cnt <= cnt + CW'(1);
      end
      if ((state == REQ) & (mem.mem_gnt | timeout))
        req_q <= 1'b0;
      if (finish) begin
        o_load_data <= (resp_ok & ~we_q) ? load_ext : '0;
        o_bus_err   <= resp_ok ? mem.mem_err : 1'b1;
      end
    end
  end

  assign mem.mem_req   = req_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;
  assign mem.mem_wstrb = wstrb_q;

endmodule

// File: tb/tb_p4_mem.sv
// Directed bench for p4_mem: a vector table of complete bus transactions plus
// hand-written sequences for timeouts, late responses and mid-transaction reset.
module tb_p4_mem;
  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_valid, i_mem_rd, i_mem_wr;
  logic [2:0]  i_funct3;
  logic [31:0] i_alu_out, i_rd_data2;
  logic        o_stall, o_done, o_misaligned, o_bus_err;
  logic [31:0] o_load_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  p4_mem_if bus();

  p4_mem #(.TIMEOUT_CYCLES(TO)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .i_mem_rd(i_mem_rd),
    .i_mem_wr(i_mem_wr), .i_funct3(i_funct3), .i_alu_out(i_alu_out),
    .i_rd_data2(i_rd_data2), .o_stall(o_stall), .o_load_data(o_load_data),
    .o_done(o_done), .o_misaligned(o_misaligned), .o_bus_err(o_bus_err),
    .mem(bus)
  );

  typedef struct {
    logic        rd, wr;
    logic [2:0]  f3;
    logic [31:0] addr, rs2, rdata;
    logic        err;
    int unsigned gd;
    logic        mis;
    logic [31:0] e_addr;
    logic        e_we;
    logic [31:0] e_wdata;
    logic [3:0]  e_wstrb;
    logic [31:0] e_load;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rd, logic wr, logic [2:0] f3, logic [31:0] addr,
                              logic [31:0] rs2, logic [31:0] rdata, logic err,
                              int unsigned gd, logic mis, logic [31:0] e_addr,
                              logic e_we, logic [31:0] e_wdata, logic [3:0] e_wstrb,
                              logic [31:0] e_load);
    vec_t v;
    v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = addr; v.rs2 = rs2; v.rdata = rdata;
    v.err = err; v.gd = gd; v.mis = mis; v.e_addr = e_addr; v.e_we = e_we;
    v.e_wdata = e_wdata; v.e_wstrb = e_wstrb; v.e_load = e_load;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_valid = 1'b0; i_mem_rd = 1'b0; i_mem_wr = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string p;
    p = $sformatf("v%0d_", idx);
    i_valid = 1'b1; i_mem_rd = v.rd; i_mem_wr = v.wr; i_funct3 = v.f3;
    i_alu_out = v.addr; i_rd_data2 = v.rs2;
    #1;
    if (v.mis) begin
      chk({p, "misaligned"}, 32'(o_misaligned), 32'd1);
      chk({p, "stall"}, 32'(o_stall), 32'd0);
      step();
      chk({p, "req_after_mis"}, 32'(bus.mem_req), 32'd0);
      idle_inputs();
      #1;
      chk({p, "mis_cleared"}, 32'(o_misaligned), 32'd0);
      step();
      chk({p, "req_idle"}, 32'(bus.mem_req), 32'd0);
      chk({p, "done_idle"}, 32'(o_done), 32'd0);
      return;
    end
    chk({p, "misaligned"}, 32'(o_misaligned), 32'd0);
    chk({p, "stall_start"}, 32'(o_stall), 32'd1);
    step();
    for (int unsigned k = 0; k < v.gd; k++) begin
      chk({p, "req"}, 32'(bus.mem_req), 32'd1);
      chk({p, "stall_req"}, 32'(o_stall), 32'd1);
      chk({p, "addr"}, bus.mem_addr, v.e_addr);
      chk({p, "we"}, 32'(bus.mem_we), 32'(v.e_we));
      chk({p, "wdata"}, bus.mem_wdata, v.e_wdata);
      chk({p, "wstrb"}, 32'(bus.mem_wstrb), 32'(v.e_wstrb));
      if (k == v.gd - 1) bus.mem_gnt = 1'b1;
      step();
      bus.mem_gnt = 1'b0;
    end
    chk({p, "req_resp"}, 32'(bus.mem_req), 32'd0);
    chk({p, "stall_resp"}, 32'(o_stall), 32'd1);
    chk({p, "done_resp"}, 32'(o_done), 32'd0);
    bus.mem_rvalid = 1'b1; bus.mem_rdata = v.rdata; bus.mem_err = v.err;
    step();
    bus.mem_rvalid = 1'b0; bus.mem_err = 1'b0;
    idle_inputs();
    #1;
    chk({p, "done"}, 32'(o_done), 32'd1);
    chk({p, "load_data"}, o_load_data, v.e_load);
    chk({p, "bus_err"}, 32'(o_bus_err), 32'(v.err));
    chk({p, "stall_done"}, 32'(o_stall), 32'd0);
    step();
    chk({p, "done_clear"}, 32'(o_done), 32'd0);
    chk({p, "bus_err_clear"}, 32'(o_bus_err), 32'd0);
  endtask

  initial begin
    vecs.push_back(mk(1,0,3'b000,32'h1003,0,32'h80FF_FF00,0,2,0,32'h1000,0,0,4'h0,32'hFFFF_FF80));
    vecs.push_back(mk(0,1,3'b001,32'h2002,32'h1234_ABCD,32'hDEAD_BEEF,0,1,0,32'h2000,1,32'hABCD_ABCD,4'b1100,0));
    vecs.push_back(mk(1,0,3'b100,32'h1001,0,32'h1122_8344,0,1,0,32'h1000,0,0,4'h0,32'h0000_0083));
    vecs.push_back(mk(1,0,3'b000,32'h1000,0,32'h1234_5678,0,1,0,32'h1000,0,0,4'h0,32'h0000_0078));
    vecs.push_back(mk(1,0,3'b001,32'h4002,0,32'h8001_7FFF,0,2,0,32'h4000,0,0,4'h0,32'hFFFF_8001));
    vecs.push_back(mk(1,0,3'b101,32'h4000,0,32'h8001_F00D,0,1,0,32'h4000,0,0,4'h0,32'h0000_F00D));
    vecs.push_back(mk(1,0,3'b010,32'h5004,0,32'hCAFE_BABE,0,1,0,32'h5004,0,0,4'h0,32'hCAFE_BABE));
    vecs.push_back(mk(0,1,3'b000,32'h6001,32'h0000_00A5,0,0,1,0,32'h6000,1,32'hA5A5_A5A5,4'b0010,0));
    vecs.push_back(mk(0,1,3'b000,32'h6003,32'hFFFF_FF7E,0,0,2,0,32'h6000,1,32'h7E7E_7E7E,4'b1000,0));
    vecs.push_back(mk(0,1,3'b010,32'h7000,32'h89AB_CDEF,0,0,2,0,32'h7000,1,32'h89AB_CDEF,4'hF,0));
    vecs.push_back(mk(1,1,3'b010,32'h8000,32'h1122_3344,32'hFFFF_FFFF,0,1,0,32'h8000,1,32'h1122_3344,4'hF,0));
    vecs.push_back(mk(1,0,3'b011,32'h9000,0,32'h8765_4321,0,1,0,32'h9000,0,0,4'h0,32'h8765_4321));
    vecs.push_back(mk(1,0,3'b010,32'hC000,0,32'h0BAD_0BAD,1,1,0,32'hC000,0,0,4'h0,32'h0BAD_0BAD));
    vecs.push_back(mk(1,0,3'b010,32'h3001,0,0,0,1,1,0,0,0,4'h0,0));
    vecs.push_back(mk(1,0,3'b001,32'h3003,0,0,0,1,1,0,0,0,4'h0,0));
    vecs.push_back(mk(0,1,3'b001,32'h3001,32'h5555_5555,0,0,1,1,0,0,0,4'h0,0));

    rst_n = 1'b0;
    idle_inputs();
    i_funct3 = '0; i_alu_out = '0; i_rd_data2 = '0;
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0; bus.mem_err = 1'b0;
    repeat (2) step();
    chk("rst_req", 32'(bus.mem_req), 32'd0);
    chk("rst_done", 32'(o_done), 32'd0);
    chk("rst_load", o_load_data, 32'd0);
    chk("rst_stall", 32'(o_stall), 32'd0);
    rst_n = 1'b1;
    step();

    // Non-memory instruction, then a load with i_valid low: neither may start
    i_valid = 1'b1;
    #1;
    chk("nonmem_stall", 32'(o_stall), 32'd0);
    chk("nonmem_mis", 32'(o_misaligned), 32'd0);
    step();
    chk("nonmem_req", 32'(bus.mem_req), 32'd0);
    i_valid = 1'b0; i_mem_rd = 1'b1; i_alu_out = 32'h1001; i_funct3 = 3'b010;
    #1;
    chk("novalid_stall", 32'(o_stall), 32'd0);
    chk("novalid_mis", 32'(o_misaligned), 32'd0);
    step();
    chk("novalid_req", 32'(bus.mem_req), 32'd0);
    chk("novalid_done", 32'(o_done), 32'd0);
    idle_inputs();

    foreach (vecs[i]) run_vec(vecs[i], i);

    // LHU granted at once but never answered: aborts after TO REQ/RESP cycles
    i_valid = 1'b1; i_mem_rd = 1'b1; i_funct3 = 3'b101; i_alu_out = 32'h4000;
    step();
    chk("to1_req", 32'(bus.mem_req), 32'd1);
    bus.mem_gnt = 1'b1;
    step();
    bus.mem_gnt = 1'b0;
    for (int unsigned k = 0; k < TO - 1; k++) begin
      chk("to1_stall", 32'(o_stall), 32'd1);
      chk("to1_early_done", 32'(o_done), 32'd0);
      step();
    end
    idle_inputs();
    #1;
    chk("to1_done", 32'(o_done), 32'd1);
    chk("to1_bus_err", 32'(o_bus_err), 32'd1);
    chk("to1_load", o_load_data, 32'd0);
    step();
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h1234_5678;
    #1;
    chk("late_stall", 32'(o_stall), 32'd0);
    step();
    bus.mem_rvalid = 1'b0;
    chk("late_done", 32'(o_done), 32'd0);
    chk("late_bus_err", 32'(o_bus_err), 32'd0);
    chk("late_load", o_load_data, 32'd0);
    step();
    chk("late_done2", 32'(o_done), 32'd0);

    // SW never granted: request held for TO cycles, then dropped with an error
    i_valid = 1'b1; i_mem_wr = 1'b1; i_funct3 = 3'b010; i_alu_out = 32'hA000;
    i_rd_data2 = 32'h0F0F_0F0F;
    step();
    for (int unsigned k = 0; k < TO; k++) begin
      chk("to2_req", 32'(bus.mem_req), 32'd1);
      chk("to2_stall", 32'(o_stall), 32'd1);
      step();
    end
    idle_inputs();
    #1;
    chk("to2_done", 32'(o_done), 32'd1);
    chk("to2_bus_err", 32'(o_bus_err), 32'd1);
    chk("to2_req_drop", 32'(bus.mem_req), 32'd0);
    step();

    // Reset asserted mid-request clears everything immediately and is not replayed
    i_valid = 1'b1; i_mem_wr = 1'b1; i_funct3 = 3'b010; i_alu_out = 32'hB000;
    i_rd_data2 = 32'h55AA_55AA;
    step();
    chk("rst2_req_before", 32'(bus.mem_req), 32'd1);
    idle_inputs();
    rst_n = 1'b0;
    #1;
    chk("rst2_req", 32'(bus.mem_req), 32'd0);
    chk("rst2_addr", bus.mem_addr, 32'd0);
    chk("rst2_wdata", bus.mem_wdata, 32'd0);
    chk("rst2_wstrb", 32'(bus.mem_wstrb), 32'd0);
    chk("rst2_we", 32'(bus.mem_we), 32'd0);
    chk("rst2_done", 32'(o_done), 32'd0);
    chk("rst2_bus_err", 32'(o_bus_err), 32'd0);
    chk("rst2_stall", 32'(o_stall), 32'd0);
    step();
    rst_n = 1'b1;
    i_valid = 1'b1;
    #1;
    chk("add_stall", 32'(o_stall), 32'd0);
    for (int unsigned k = 0; k < 3; k++) begin
      step();
      chk("add_req", 32'(bus.mem_req), 32'd0);
      chk("add_stall_n", 32'(o_stall), 32'd0);
      chk("add_done", 32'(o_done), 32'd0);
    end
    idle_inputs();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end
endmodule

// File: doc/p4_mem.md
P4_MEM -- requirements
Module: p4_mem

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16, max cycles from bus request to response before abort.
REQ-002 i_clk  input  1  clock; all state updates on rising edge.
REQ-003 i_rst_n  input  1  asynchronous active-low reset.
REQ-004 i_valid  input  1  P3/P4 pipeline register holds a live instruction.
REQ-005 i_mem_rd  input  1  instruction is a load.
REQ-006 i_mem_wr  input  1  instruction is a store.
REQ-007 i_funct3  input  3  access size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-008 i_alu_out  input  32  effective byte address.
REQ-009 i_rd_data2  input  32  store data (rs2).
REQ-010 o_stall  output  1  hold P3/P4 and all upstream stages.
REQ-011 o_load_data  output  32  extended load result, valid when o_done=1.
REQ-012 o_done  output  1  memory access completed this cycle.
REQ-013 o_misaligned  output  1  misaligned access detected; no bus traffic issued.
REQ-014 o_bus_err  output  1  bus error or timeout on the completing access.
REQ-015 o_mem_req / i_mem_gnt  output / input  1 / 1  request handshake; a transfer is accepted on the cycle both are 1.
REQ-016 o_mem_we  output  1  1 store, 0 load.
REQ-017 o_mem_addr  output  32  word-aligned address {addr[31:2],2'b00}.
REQ-018 o_mem_wdata / o_mem_wstrb  output  32 / 4  lane-replicated store data and byte strobes.
REQ-019 i_mem_rvalid / i_mem_rdata / i_mem_err  input  1 / 32 / 1  response strobe, read word, error flag.

Function
REQ-020 FSM states IDLE, REQ, RESP, DONE; o_mem_*, o_load_data, o_done and o_bus_err SHALL be registered.
REQ-021 IDLE: start = i_valid & (i_mem_rd | i_mem_wr) & aligned; on start capture address, we, wdata, wstrb and funct3, then go to REQ.
REQ-022 Alignment: H/HU requires addr[0]=0; W requires addr[1:0]=0; B/BU is always aligned.
REQ-023 A misaligned access in IDLE SHALL assert o_misaligned combinationally for that cycle, with o_stall=0, no state change and no bus request.
REQ-024 REQ: o_mem_req=1 with all bus fields stable until i_mem_gnt=1, then go to RESP.
REQ-025 RESP: on i_mem_rvalid capture the extended i_mem_rdata (loads) or 0 (stores) into o_load_data and i_mem_err into o_bus_err, then go to DONE.
REQ-026 DONE lasts exactly one cycle with o_done=1 and o_stall=0; inputs are ignored; then return to IDLE.
REQ-027 o_stall = (IDLE & start) | REQ | RESP.
REQ-028 Timeout counter clears on entry to REQ and increments each REQ/RESP cycle.
REQ-029 On reaching TIMEOUT_CYCLES the FSM SHALL go to DONE with o_bus_err=1 and o_load_data=0; a late i_mem_rvalid arriving in IDLE is ignored.
REQ-030 Store lanes: SB wstrb=4'b0001<<addr[1:0], wdata={4{rs2[7:0]}}; SH wstrb=4'b0011<<(2*addr[1]), wdata={2{rs2[15:0]}}; SW wstrb=4'hF, wdata=rs2.
REQ-031 Load extract: B/BU take byte addr[1:0]; H/HU take half addr[1]; sign-extend for B/H, zero-extend for BU/HU, no extension for W.
REQ-032 Reserved load funct3 values SHALL be treated as W; loads drive o_mem_wstrb=0.
REQ-033 A non-memory instruction, or i_valid=0, SHALL cause no state change, with o_stall=0 and o_done=0.
REQ-034 If i_mem_rd and i_mem_wr are both set, the access SHALL be treated as a store.

Reset
REQ-035 While i_rst_n=0 the FSM is in IDLE and all registered outputs, the captured fields and the counter are 0; o_mem_req SHALL drop immediately even mid-transaction.
REQ-036 An aborted transaction SHALL NOT be replayed after reset release.

Verification
REQ-037 LB, addr 0x1003, gnt after 2 cycles, rdata 0x80FF_FF00 one cycle later -> o_mem_addr 0x1000; o_stall high 1+2+1 cycles; o_done with o_load_data 0xFFFF_FF80.
REQ-038 SH, addr 0x2002, rs2 0x1234_ABCD -> wstrb 4'b1100, wdata 0xABCD_ABCD, we=1; o_done one cycle after rvalid.
REQ-039 LW, addr 0x3001 -> o_misaligned=1 for one cycle, o_stall=0, o_mem_req never asserted.
REQ-040 LHU with gnt but no rvalid, TIMEOUT_CYCLES=4 -> DONE after 4 REQ/RESP cycles with o_bus_err=1, o_load_data=0; a later rvalid has no effect.
REQ-041 i_rst_n low while in REQ -> o_mem_req=0 asynchronously, all outputs 0, FSM in IDLE; after release an ADD instruction gives o_stall=0.
